seq_detector_n: RTL and testbench

- Parametrised successor to the fixed 3-bit "111" serial detector FSM.
- Detects a programmable N-bit pattern on a 1-bit serial input.
- Supports overlapping and non-overlapping detection, a clock-enable, runtime pattern reload, and a saturating match counter.
- Sits on a serial bit stream and drives a one-cycle match pulse plus statistics to downstream logic.

---
 rtl/seq_detector_n.sv | 90 +++++++++
 tb/tb_seq_detector_n.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_n.sv
// Serial N-bit pattern detector with overlap control, clock-enable, runtime
// pattern reload and a saturating match counter.
module seq_detector_n #(
  parameter int unsigned N = 3,
  parameter logic [N-1:0] DEFAULT_PATTERN = {N{1'b1}},
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     x,
  input  logic                     load,
  input  logic [N-1:0]             pattern,
  input  logic                     overlap,
  output logic                     match,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     cnt_sat,
  output logic [$clog2(N+1)-1:0]   fill
);

  localparam int unsigned FW = $clog2(N+1);
  localparam logic [FW-1:0] FULL = FW'(N);

  // fill is the state; phase is its coarse decode
  typedef enum logic [1:0] {EMPTY, PARTIAL, ARMED} phase_t;

  phase_t          phase;
  logic [N-1:0]    hist;
  logic [N-1:0]    hist_nx;
  logic [N-1:0]    hist_shift;
  logic [N-1:0]    pat_reg;
  logic [N-1:0]    pat_nx;
  logic [FW-1:0]   fill_nx;
  logic [FW-1:0]   fill_inc;
  logic            match_nx;
  logic            hit;
  logic [CNT_W-1:0] cnt_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist      <= '0;
      fill      <= '0;
      pat_reg   <= DEFAULT_PATTERN;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      hist      <= hist_nx;
      fill      <= fill_nx;
      pat_reg   <= pat_nx;
      match     <= match_nx;
      match_cnt <= cnt_nx;
    end
  end

  // next-state: load beats en beats idle
  always_comb begin
    phase      = PARTIAL;
    hist_nx    = hist;
    fill_nx    = fill;
    pat_nx     = pat_reg;
    match_nx   = 1'b0;
    cnt_nx     = match_cnt;

    if (fill == '0)        phase = EMPTY;
    else if (fill == FULL) phase = ARMED;

    hist_shift = {hist[N-2:0], x};
    fill_inc   = (phase == ARMED) ? FULL : fill + FW'(1);
    hit        = (fill_inc == FULL) && (hist_shift == pat_reg);

    if (load) begin
      pat_nx  = pattern;
      hist_nx = '0;
      fill_nx = '0;
      cnt_nx  = '0;
    end else if (en) begin
      hist_nx  = hist_shift;
      fill_nx  = fill_inc;
      match_nx = hit;
      if (hit) begin
        if (!cnt_sat) cnt_nx = match_cnt + CNT_W'(1);
        // non-overlap: stale history is ignored until N new bits arrive
        if (!overlap) fill_nx = '0;
      end
    end
  end

  assign cnt_sat = &match_cnt;

endmodule

// File: tb/tb_seq_detector_n.sv
// Bench for seq_detector_n: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_seq_detector_n;

  localparam int unsigned N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         x = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] pattern = '0;
  logic         overlap = 1'b1;

  logic         match_a, sat_a, match_b, sat_b;
  logic [7:0]   cnt_a;
  logic [1:0]   cnt_b;
  logic [1:0]   fill_a, fill_b;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  seq_detector_n #(.N(N), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pattern(pattern),
    .overlap(overlap), .match(match_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .fill(fill_a)
  );

  seq_detector_n #(.N(N), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pattern(pattern),
    .overlap(overlap), .match(match_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .fill(fill_b)
  );

  always #5 clk = ~clk;

  // Model: keep the bits received since the last clear, newest at the back
  int           q[$];
  logic [N-1:0] m_pat = '1;
  bit           m_match = 1'b0;
  int           m_cnt8 = 0;
  int           m_cnt2 = 0;

  always @(posedge clk or posedge reset) begin
    bit h;
    if (reset) begin
      q.delete();
      m_pat = '1; m_match = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (load) begin
      q.delete();
      m_pat = pattern; m_match = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (en) begin
      q.push_back(int'(x));
      if (q.size() > N) void'(q.pop_front());
      h = (q.size() == N);
      for (int i = 0; i < N; i++)
        if (h && q[i] != int'(m_pat[N-1-i])) h = 1'b0;
      m_match = h;
      if (h) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!overlap) q.delete();
      end
    end else begin
      m_match = 1'b0;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("match_a", int'(match_a), int'(m_match));
      chk("cnt_a", int'(cnt_a), m_cnt8);
      chk("sat_a", int'(sat_a), int'(m_cnt8 == 255));
      chk("fill_a", int'(fill_a), q.size());
      chk("cnt_b", int'(cnt_b), m_cnt2);
      chk("sat_b", int'(sat_b), int'(m_cnt2 == 3));
    end
  end

  task automatic step(input logic e, input logic xi);
    en = e; x = xi; load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [N-1:0] p, input logic e, input logic xi);
    en = e; x = xi; load = 1'b1; pattern = p;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0; load = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] exp5;
    logic [6:0] exp7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", int'(match_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_fill", int'(fill_a), 0);
    chk("rst_sat", int'(sat_b), 0);
    reset = 1'b0;
    chk_on = 1'b1;

    // 1: overlapping 111
    overlap = 1'b1;
    exp5 = 5'b11100;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      chk("t1_match", int'(match_a), int'(exp5[i]));
    end
    chk("t1_cnt", int'(cnt_a), 3);
    chk("t1_fill", int'(fill_a), 3);

    // 2: non-overlapping 111
    do_reset();
    overlap = 1'b0;
    exp7 = 7'b0100100;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1);
      chk("t2_match", int'(match_a), int'(exp7[i]));
    end
    chk("t2_cnt", int'(cnt_a), 2);
    chk("t2_fill", int'(fill_a), 1);

    // 3: pattern 101 on 10101
    overlap = 1'b1;
    do_load(3'b101, 1'b0, 1'b0);
    exp5 = 5'b10100;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'(i % 2 == 0));
      chk("t3o_match", int'(match_a), int'(exp5[i]));
    end
    chk("t3o_cnt", int'(cnt_a), 2);
    overlap = 1'b0;
    do_load(3'b101, 1'b0, 1'b0);
    exp5 = 5'b00100;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'(i % 2 == 0));
      chk("t3n_match", int'(match_a), int'(exp5[i]));
    end
    chk("t3n_cnt", int'(cnt_a), 1);

    // 4: enable gap
    do_reset();
    overlap = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("t4_gap", int'(match_a), 0);
    step(1'b0, 1'b0);
    chk("t4_gap", int'(match_a), 0);
    step(1'b1, 1'b1);
    chk("t4_match", int'(match_a), 1);
    chk("t4_cnt", int'(cnt_a), 1);

    // 5: narrow counter saturates
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    chk("t5_cnt_b", int'(cnt_b), 3);
    chk("t5_sat_b", int'(sat_b), 1);
    chk("t5_cnt_a", int'(cnt_a), 6);

    // 6a: async reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_cnt", int'(cnt_a), 0);
    chk("t6_rst_fill", int'(fill_a), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("t6_nomatch", int'(match_a), 0);
    step(1'b1, 1'b1);
    chk("t6_match", int'(match_a), 1);

    // 6b: load wins over en on the same edge
    do_load(3'b011, 1'b1, 1'b1);
    chk("t6_load_fill", int'(fill_a), 0);
    chk("t6_load_cnt", int'(cnt_a), 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("t6_load_early", int'(match_a), 0);
    step(1'b1, 1'b1);
    chk("t6_load_match", int'(match_a), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      overlap = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 49) == 0) begin
        do_load(N'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
